// File: rtl/efx_srl_tap.sv
// Variable-depth addressable shift register with fill tracking, per-tap valid
// flags and an optional output register stage.
module efx_srl_tap #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 16,
  parameter int              OUT_REG = 1,
  parameter logic [WIDTH-1:0] INIT   = '0,
  localparam int             AW      = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int             FW      = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic [WIDTH-1:0] QL,
  output logic             QL_VALID,
  output logic [FW-1:0]    FILL
);

  // Storage carries its power-up value and is deliberately never reset.
  logic [WIDTH-1:0] stage_q [DEPTH] = '{default: INIT};
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    fill_d;

  logic [WIDTH-1:0] q_d;
  logic             q_valid_d;
  logic [WIDTH-1:0] ql_d;
  logic             ql_valid_d;

  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (!RST && CE) begin
      stage_d[0] = D;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
      if (fill_q != FW'(DEPTH)) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    stage_q <= stage_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  // Tap addresses at or beyond DEPTH read as an invalid zero word.
  always_comb begin
    q_d       = '0;
    q_valid_d = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (A == AW'(k)) begin
        q_d       = stage_q[k];
        q_valid_d = (FW'(k) < fill_q);
      end
    end
    ql_d       = stage_q[DEPTH-1];
    ql_valid_d = (fill_q == FW'(DEPTH));
  end

  assign FILL = fill_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] q_q;
      logic             q_valid_q;
      logic [WIDTH-1:0] ql_q;
      logic             ql_valid_q;

      // Loads every cycle regardless of CE so A changes still propagate.
      always_ff @(posedge CLK) begin
        if (RST) begin
          q_q        <= '0;
          q_valid_q  <= 1'b0;
          ql_q       <= '0;
          ql_valid_q <= 1'b0;
        end else begin
          q_q        <= q_d;
          q_valid_q  <= q_valid_d;
          ql_q       <= ql_d;
          ql_valid_q <= ql_valid_d;
        end
      end

      assign Q        = q_q;
      assign Q_VALID  = q_valid_q;
      assign QL       = ql_q;
      assign QL_VALID = ql_valid_q;
    end else begin : g_out_comb
      assign Q        = q_d;
      assign Q_VALID  = q_valid_d;
      assign QL       = ql_d;
      assign QL_VALID = ql_valid_d;
    end
  endgenerate

endmodule

// File: tb/tb_efx_srl_tap.sv
// Directed bench: three instances (16-deep comb, 16-deep registered, 12-deep comb)
// share one stimulus stream and are checked against hand-computed values.
module tb_efx_srl_tap;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [7:0] d;
  logic [3:0] a;

  logic [7:0] q0, ql0, q1, ql1, q2, ql2;
  logic       qv0, qlv0, qv1, qlv1, qv2, qlv2;
  logic [4:0] fill0, fill1;
  logic [3:0] fill2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  efx_srl_tap #(.WIDTH(8), .DEPTH(16), .OUT_REG(0)) u_comb (
    .CLK(clk), .RST(rst), .CE(ce), .D(d), .A(a),
    .Q(q0), .Q_VALID(qv0), .QL(ql0), .QL_VALID(qlv0), .FILL(fill0)
  );

  efx_srl_tap #(.WIDTH(8), .DEPTH(16), .OUT_REG(1)) u_reg (
    .CLK(clk), .RST(rst), .CE(ce), .D(d), .A(a),
    .Q(q1), .Q_VALID(qv1), .QL(ql1), .QL_VALID(qlv1), .FILL(fill1)
  );

  efx_srl_tap #(.WIDTH(8), .DEPTH(12), .OUT_REG(0)) u_d12 (
    .CLK(clk), .RST(rst), .CE(ce), .D(d), .A(a),
    .Q(q2), .Q_VALID(qv2), .QL(ql2), .QL_VALID(qlv2), .FILL(fill2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic shift(input logic [7:0] w);
    d  = w;
    ce = 1'b1;
    tick();
    ce = 1'b0;
  endtask

  task automatic set_a(input logic [3:0] v);
    a = v;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ce = 1'b0; d = 8'h00; a = 4'd0;

    // Reset state
    do_reset();
    chk("rst_fill0", 64'(fill0), 64'd0);
    chk("rst_qv0", 64'(qv0), 64'd0);
    chk("rst_qlv0", 64'(qlv0), 64'd0);
    chk("rst_q0_init", 64'(q0), 64'h00);
    chk("rst_q1", 64'(q1), 64'h00);
    chk("rst_qv1", 64'(qv1), 64'd0);
    chk("rst_ql1", 64'(ql1), 64'h00);
    chk("rst_fill2", 64'(fill2), 64'd0);

    // Fill and tap: words 1..5
    for (int i = 1; i <= 5; i++) shift(8'(i));
    chk("f5_fill0", 64'(fill0), 64'd5);
    chk("f5_fill1", 64'(fill1), 64'd5);
    set_a(4'd0);
    chk("f5_a0_q", 64'(q0), 64'd5);
    chk("f5_a0_qv", 64'(qv0), 64'd1);
    set_a(4'd4);
    chk("f5_a4_q", 64'(q0), 64'd1);
    chk("f5_a4_qv", 64'(qv0), 64'd1);
    set_a(4'd5);
    chk("f5_a5_qv", 64'(qv0), 64'd0);
    chk("f5_qlv0", 64'(qlv0), 64'd0);

    // Saturation: words 6..20
    for (int i = 6; i <= 20; i++) shift(8'(i));
    chk("f20_fill0", 64'(fill0), 64'd16);
    chk("f20_ql0", 64'(ql0), 64'd5);
    chk("f20_qlv0", 64'(qlv0), 64'd1);
    set_a(4'd15);
    chk("f20_a15_q", 64'(q0), 64'd5);
    chk("f20_a15_qv", 64'(qv0), 64'd1);
    chk("d12_fill", 64'(fill2), 64'd12);
    chk("d12_ql", 64'(ql2), 64'd9);
    chk("d12_qlv", 64'(qlv2), 64'd1);
    for (int k = 12; k <= 15; k++) begin
      set_a(4'(k));
      chk("d12_oob_q", 64'(q2), 64'd0);
      chk("d12_oob_qv", 64'(qv2), 64'd0);
    end
    set_a(4'd11);
    chk("d12_a11_q", 64'(q2), 64'd9);
    chk("d12_a11_qv", 64'(qv2), 64'd1);
    set_a(4'd15);
    tick();
    chk("reg_a15_q", 64'(q1), 64'd5);
    chk("reg_a15_qv", 64'(qv1), 64'd1);
    chk("reg_ql", 64'(ql1), 64'd5);
    chk("reg_qlv", 64'(qlv1), 64'd1);
    shift(8'd21);
    chk("f21_fill0", 64'(fill0), 64'd16);
    chk("f21_ql0", 64'(ql0), 64'd6);

    // Reset priority over CE
    do_reset();
    for (int i = 0; i < 10; i++) shift(8'h31 + 8'(i));
    chk("rp_fill10", 64'(fill0), 64'd10);
    rst = 1'b1; ce = 1'b1; d = 8'hAA;
    tick();
    rst = 1'b0; ce = 1'b0;
    chk("rp_fill0", 64'(fill0), 64'd0);
    chk("rp_qlv0", 64'(qlv0), 64'd0);
    set_a(4'd0);
    chk("rp_a0_q", 64'(q0), 64'h3A);
    chk("rp_a0_qv", 64'(qv0), 64'd0);
    chk("rp_reg_q", 64'(q1), 64'h00);
    chk("rp_reg_qv", 64'(qv1), 64'd0);
    chk("rp_reg_ql", 64'(ql1), 64'h00);
    chk("rp_reg_qlv", 64'(qlv1), 64'd0);
    shift(8'h55);
    chk("rp_next_fill", 64'(fill0), 64'd1);
    chk("rp_next_a0_q", 64'(q0), 64'h55);
    chk("rp_next_a0_qv", 64'(qv0), 64'd1);
    set_a(4'd1);
    chk("rp_next_a1_q", 64'(q0), 64'h3A);
    chk("rp_next_a1_qv", 64'(qv0), 64'd0);

    // CE gating with A toggling into the registered instance
    do_reset();
    shift(8'h61); shift(8'h62); shift(8'h63);
    for (int i = 0; i < 10; i++) begin
      a = 4'(i % 3);
      d = 8'hC0 ^ 8'(i);
      tick();
      chk("ceg_fill", 64'(fill0), 64'd3);
      chk("ceg_reg_q", 64'(q1), 64'(8'h63 - 8'(i % 3)));
      chk("ceg_reg_qv", 64'(qv1), 64'd1);
    end
    set_a(4'd0);
    chk("ceg_a0", 64'(q0), 64'h63);
    set_a(4'd2);
    chk("ceg_a2", 64'(q0), 64'h61);
    set_a(4'd3);
    chk("ceg_a3_qv", 64'(qv0), 64'd0);

    // Output register latency with A fixed at 2
    do_reset();
    a = 4'd2;
    shift(8'h10);
    shift(8'h11);
    chk("lat_e2_reg_qv", 64'(qv1), 64'd0);
    shift(8'h12);
    chk("lat_e3_comb_q", 64'(q0), 64'h10);
    chk("lat_e3_comb_qv", 64'(qv0), 64'd1);
    chk("lat_e3_reg_qv", 64'(qv1), 64'd0);
    tick();
    chk("lat_e4_reg_q", 64'(q1), 64'h10);
    chk("lat_e4_reg_qv", 64'(qv1), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/efx_srl_tap.md
# efx_srl_tap

Parametrised, multi-bit, variable-depth addressable shift register with occupancy tracking and optional output register. It generalises the 8-deep single-bit SRL primitive to WIDTH-bit words and DEPTH stages, and adds a synchronous reset, a fill counter and per-tap valid flags. The scaler datapath uses it for short pixel and control delay lines, such as tap alignment and sideband delay matching, where downstream logic must know whether the selected tap holds real data yet.

## Interface
- WIDTH, 8: data word width in bits; legal range 1..64.
- DEPTH, 16: number of shift stages; legal range 2..64; need not be a power of two.
- OUT_REG, 1: selects the output path. 1 registers the Q, Q_VALID, QL and QL_VALID outputs. 0 makes them combinational from storage.
- INIT, 0: power-up value of every storage stage; WIDTH bits, replicated across all stages.
- Derived: AW = max(1, clog2(DEPTH)); FW = clog2(DEPTH+1).

- CLK  in  1  clock; rising edge only.
- RST  in  1  reset; synchronous, active-high.
- CE  in  1  shift enable, active-high.
- D  in  WIDTH  word shifted into stage 0 when CE=1.
- A  in  AW  tap select for Q; 0 = newest stage.
- Q  out  WIDTH  word at stage A.
- Q_VALID  out  1  stage A holds a word written since the last reset.
- QL  out  WIDTH  word at stage DEPTH-1, the oldest stage.
- QL_VALID  out  1  the pipeline is full (FILL == DEPTH).
- FILL  out  FW  count of valid stages, saturating at DEPTH.

## Operation
- Storage: stage[0..DEPTH-1], each WIDTH bits, initialised to INIT at time zero. RST never clears storage.
- Shift: on a rising edge with CE=1 and RST=0, stage[0] <= D and stage[k] <= stage[k-1] for k = 1..DEPTH-1. With CE=0 all stages hold.
- Fill counter: on a shift edge with FILL < DEPTH, FILL increments by 1. At FILL == DEPTH it holds. There is no wrap.
- Combinational tap values:
  - qc = stage[A], qvc = (A < FILL).
  - If A >= DEPTH (possible when DEPTH is not a power of two): qc = 0 and qvc = 0.
  - qlc = stage[DEPTH-1], qlvc = (FILL == DEPTH).
- OUT_REG=0: Q = qc, Q_VALID = qvc, QL = qlc, QL_VALID = qlvc.
- OUT_REG=1: Q, Q_VALID, QL and QL_VALID are registers. They load qc, qvc, qlc and qlvc every cycle, ungated by CE, with the values taken from pre-edge state.
- RST=1 at an edge:
  - FILL <= 0.
  - Output registers (OUT_REG=1) <= 0.
  - The shift is suppressed even if CE=1; RST wins over CE.
- Reset values: FILL = 0, Q_VALID = 0, QL_VALID = 0. Q and QL are 0 when OUT_REG=1. When OUT_REG=0, Q and QL show storage contents, which are INIT or retained data.
- Reset mid-operation: storage contents survive. All valid flags drop to 0, and each refills only as new words are shifted in.
- A may change every cycle; no state depends on A.

## Timing
- Word W shifted at edge n (CE=1):
  - With OUT_REG=0, W is visible on Q with A=k from just after edge n+k, assuming k further shifts.
  - More generally, W reaches stage k after k additional CE edges.
- OUT_REG=1 adds exactly one CLK of latency to Q, Q_VALID, QL and QL_VALID, regardless of CE.
- FILL updates on the same edge as the shift and is never registered twice; it carries no extra latency in either mode.
- Q_VALID for tap k first asserts after the (k+1)-th shift following reset, plus one cycle if OUT_REG=1.
- RST asserted at edge r:
  - FILL reads 0 after edge r.
  - With OUT_REG=1, the registered outputs read 0 after edge r.
  - The first shift after reset is at the first edge with RST=0 and CE=1.
- No combinational path exists from D to any output. With OUT_REG=0, A and the storage/FILL state drive Q and Q_VALID combinationally.

## Test plan
- Fill and tap: WIDTH=8, DEPTH=16, OUT_REG=0. RST, then shift 1,2,3,... on consecutive edges with CE=1.
  - After 5 shifts: FILL=5; A=0 gives Q=5, Q_VALID=1; A=4 gives Q=1, Q_VALID=1; A=5 gives Q_VALID=0.
- Saturation and oldest tap: continue to 20 shifts.
  - FILL=16, QL=5, QL_VALID=1; A=15 gives Q=5.
  - FILL stays 16 after further shifts.
- CE gating: after 3 shifts, hold CE=0 for 10 cycles while toggling D.
  - FILL stays 3 and the stage contents are unchanged.
  - With OUT_REG=1, registered Q still tracks changes of A with 1-cycle latency.
- Reset priority: with FILL=10, assert RST and CE together for one edge with D=0xAA.
  - FILL=0 and all valid flags are 0.
  - Storage is unshifted: A=0 still returns the pre-reset newest word, with Q_VALID=0.
  - The next shift gives A=0 -> new word, Q_VALID=1, and A=1 -> Q_VALID=0.
- Non-power-of-two depth: DEPTH=12 (AW=4), after 15 shifts.
  - A=11 gives a valid oldest word; A=12..15 gives Q=0, Q_VALID=0.
- Output register latency: OUT_REG=1, A fixed at 2, shift 0x10, 0x11, 0x12 on edges 1..3.
  - Q=0x10 with Q_VALID=1 appears after edge 4, one cycle after the OUT_REG=0 reference model.
  - Q_VALID is 0 after edge 3.
